count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
Receiving-end checker for a WIDTH-bit binary up/down counter. It samples the counter's output and direction input every clock and verifies that each step is exactly +1 or -1 modulo 2^WIDTH, matching the direction in force.
It reports lock status, wrap events and step errors, and keeps saturating event counters.
It sits beside the counter in the Binary_counter design, on the same clock and reset, for in-system self-check and for bench scoreboarding.

Parameters:
WIDTH, 4, width of the monitored count value.
LOCK_N, 4, number of consecutive good steps required before locked asserts (range 1..15).
CNT_W, 8, width of err_cnt and wrap_cnt.

Ports:
clk  input  1  system clock; everything samples on the rising edge.
n_rst  input  1  asynchronous active-low reset.
en  input  1  monitor enable; 0 forces IDLE.
clr  input  1  synchronous clear of err_cnt and wrap_cnt.
down  input  1  counter direction input, same signal the counter sees (1 = count down).
q_in  input  WIDTH  counter output value.
locked  output  1  LOCK_N consecutive correct steps have been seen since the last resync.
err_pulse  output  1  one-cycle flag for a step mismatch.
wrap_pulse  output  1  one-cycle flag for a correct wrap (max->0 up, 0->max down).
err_cnt  output  CNT_W  saturating count of errors.
wrap_cnt  output  CNT_W  saturating count of wraps.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE.
  - locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt, good_cnt, prev_q and prev_down all 0.
- Sampling model: the counter updates on edge k using down sampled at edge k. The monitor therefore registers prev_q<=q_in and prev_down<=down on every enabled edge. At the next edge it checks q_in == prev_q + (prev_down ? -1 : +1), computed mod 2^WIDTH with WIDTH-bit truncation.
- States:
  - IDLE: en=0. No compares. locked=0. Counters hold. The edge with en=1 captures prev_q/prev_down and moves to TRACK. This is the sync sample.
  - TRACK: compare on every edge.
    - Match: good_cnt increments, saturating at LOCK_N. locked<=1 when good_cnt reaches LOCK_N.
    - Mismatch: err_pulse<=1, err_cnt increments, good_cnt<=0, locked<=0. The state stays TRACK, and the current q_in/down become the new reference (resync; no cascaded errors).
  - Any edge with en=0 moves to IDLE. locked<=0, good_cnt<=0, pulses 0.
- Wrap: a matching step with prev_q=2^WIDTH-1, prev_down=0, q_in=0, or with prev_q=0, prev_down=1, q_in=2^WIDTH-1, sets wrap_pulse<=1 and increments wrap_cnt. A mismatch never counts as a wrap.
- Latency: all outputs are registered. Flags and counters reflect the step checked at edge k during cycle k..k+1. locked rises in the cycle after the LOCK_N-th good compare.
- Pulses are high for exactly one cycle per event. Consecutive events give a continuously high pulse.
- Saturation: err_cnt and wrap_cnt stop at 2^CNT_W-1.
- clr=1: both counters <=0 on that edge, overriding any simultaneous increment. Pulses and locked are unaffected.
- Direction change: handled naturally, because prev_down applies to the step it produced. No error on a reversal.
- Reset mid-operation: immediate return to the reset values. The first enabled edge after release is a sync sample only.
- Counter held in reset while the monitor is enabled (q_in stuck at 0): reported as an error on every edge. Gating en is the integrator's responsibility.

Decomposition:
- Shared package cnt_pkg:
  - state enum {IDLE, TRACK}.
  - Function next_count(q, down) returning the modulo WIDTH-bit step. The counter RTL and the bench model use the same function.
  - Default WIDTH constant.
- One natural sub-module, sat_counter (parameter W; inputs clr, inc; output cnt). It is instantiated twice, for err_cnt and wrap_cnt.

Test Plan:
1. Reset release, en=1, counter counting up from 0 for 16 cycles -> err_pulse never high. locked high in the cycle after the 4th good compare. One wrap_pulse at 15->0. wrap_cnt=1.
2. down=1 for 16 cycles following test 1 (reversal at value 0) -> no error at the reversal. One wrap_pulse at 0->15. wrap_cnt=2, err_cnt=0.
3. Force q_in to skip 5->7 while counting up -> err_pulse one cycle. err_cnt=1. locked=0. The next good step 7->8 gives no error. locked returns after 4 good steps.
4. Drive an error on every edge for 300 cycles with CNT_W=8 -> err_cnt saturates at 255. Assert clr together with an error -> err_cnt=0 after that edge.
5. Assert n_rst=0 asynchronously mid-count (between edges) -> all outputs 0 immediately. After release, the first edge produces no compare, and a mismatch on that edge gives no err_pulse.
6. en=0 for 3 cycles mid-run, then en=1 with q_in jumped from 3 to 9 -> no err_pulse. locked=0 until 4 good steps after re-enable.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types and the counter step function used by the counter, its monitor and benches.
// Latency: none (types and pure functions only).
// Backpressure: none.
package cnt_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_e;

   // One step of a w-bit up/down counter, wrapped modulo 2^w.
   function automatic logic [31:0] next_count(input logic [31:0] q,
                                              input logic        down,
                                              input int unsigned w = DEF_WIDTH);
      logic [31:0] mask;
      logic [31:0] step;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      step = down ? (q - 32'd1) : (q + 32'd1);
      return step & mask;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible the cycle after the counted edge.
// Backpressure: none; increments past all-ones are dropped.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear beats increment; otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/count_monitor.sv
// Checks that an up/down counter steps by exactly +/-1 per clock; reports lock, wraps and errors.
// Latency: all flags/counters registered, reflecting the step checked at the previous edge.
// Backpressure: none; passive observer, samples every enabled edge.
module count_monitor
   import cnt_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int LOCK_N = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             clr,
   input  logic             down,
   input  logic [WIDTH-1:0] q_in,
   output logic             locked,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] wrap_cnt
);

   // LOCK_N is at most 15, so four bits always hold the good-step run.
   localparam int GOOD_W = 4;

   state_e              state_q;
   logic [WIDTH-1:0]    ref_q;
   logic                ref_down_q;
   logic [GOOD_W-1:0]   good_q;
   logic [GOOD_W-1:0]   good_d;
   logic                locked_q;
   logic                err_q;
   logic                wrap_q;

   logic [WIDTH-1:0]    exp_val;
   logic                tracking;
   logic                step_ok;
   logic                step_wrap;

   // Expected value from the reference sample, and classification of the current step.
   always_comb begin
      exp_val   = WIDTH'(next_count(32'(ref_q), ref_down_q, WIDTH));
      tracking  = en && (state_q == TRACK);
      step_ok   = (q_in == exp_val);
      step_wrap = step_ok && (ref_down_q ? (ref_q == '0) : (ref_q == '1));
      good_d    = (good_q >= GOOD_W'(LOCK_N)) ? GOOD_W'(LOCK_N) : good_q + GOOD_W'(1);
   end

   // Monitor FSM: sync on the first enabled edge, then compare and resync on every edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         ref_q      <= '0;
         ref_down_q <= 1'b0;
         good_q     <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         wrap_q     <= 1'b0;
      end else if (!en) begin
         state_q  <= IDLE;
         good_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         // The current sample is always the reference for the next step, so an error never cascades.
         ref_q      <= q_in;
         ref_down_q <= down;
         case (state_q)
            IDLE: begin
               state_q  <= TRACK;
               good_q   <= '0;
               locked_q <= 1'b0;
               err_q    <= 1'b0;
               wrap_q   <= 1'b0;
            end
            TRACK: begin
               if (step_ok) begin
                  good_q   <= good_d;
                  locked_q <= (good_d == GOOD_W'(LOCK_N));
                  err_q    <= 1'b0;
                  wrap_q   <= step_wrap;
               end else begin
                  good_q   <= '0;
                  locked_q <= 1'b0;
                  err_q    <= 1'b1;
                  wrap_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (clr),
      .inc   (tracking && !step_ok),
      .cnt   (err_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wrap_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (clr),
      .inc   (tracking && step_wrap),
      .cnt   (wrap_cnt)
   );

   assign locked     = locked_q;
   assign err_pulse  = err_q;
   assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed scenarios plus random traffic against a step-rule model.
// Latency: model predicts outputs visible 1 time unit after each rising edge.
// Backpressure: none.
module tb_count_monitor;

   localparam int WIDTH  = 4;
   localparam int LOCK_N = 4;
   localparam int CNT_W  = 8;
   localparam int MAXV   = (1 << WIDTH) - 1;
   localparam int CSAT   = (1 << CNT_W) - 1;

   logic             clk;
   logic             n_rst;
   logic             en;
   logic             clr;
   logic             down;
   logic [WIDTH-1:0] q_in;
   logic             locked;
   logic             err_pulse;
   logic             wrap_pulse;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] wrap_cnt;

   count_monitor #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .en         (en),
      .clr        (clr),
      .down       (down),
      .q_in       (q_in),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .wrap_pulse (wrap_pulse),
      .err_cnt    (err_cnt),
      .wrap_cnt   (wrap_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: what the monitor should report, in terms of counter values.
   bit m_trk;
   int m_ref;
   bit m_rdir;
   int m_good;
   bit m_lock, m_err, m_wrap;
   int m_ecnt, m_wcnt;

   task automatic model_reset();
      m_trk = 0; m_ref = 0; m_rdir = 0; m_good = 0;
      m_lock = 0; m_err = 0; m_wrap = 0; m_ecnt = 0; m_wcnt = 0;
   endtask

   task automatic model_edge();
      bit bad  = 0;
      bit wrp  = 0;
      int want = 0;
      if (!en) begin
         m_trk = 0; m_good = 0; m_lock = 0; m_err = 0; m_wrap = 0;
      end else if (!m_trk) begin
         m_trk = 1; m_ref = int'(q_in); m_rdir = down;
         m_good = 0; m_lock = 0; m_err = 0; m_wrap = 0;
      end else begin
         want = m_rdir ? (m_ref + MAXV) % (MAXV + 1) : (m_ref + 1) % (MAXV + 1);
         if (int'(q_in) == want) begin
            m_good = (m_good < LOCK_N) ? m_good + 1 : LOCK_N;
            m_lock = (m_good == LOCK_N);
            wrp    = m_rdir ? (m_ref == 0) : (m_ref == MAXV);
         end else begin
            bad    = 1;
            m_good = 0;
            m_lock = 0;
         end
         m_err  = bad;
         m_wrap = wrp;
         m_ref  = int'(q_in);
         m_rdir = down;
      end
      if (clr) begin
         m_ecnt = 0; m_wcnt = 0;
      end else begin
         if (bad && m_ecnt < CSAT) m_ecnt++;
         if (wrp && m_wcnt < CSAT) m_wcnt++;
      end
   endtask

   // Bench-side counter driving q_in; hold freezes it, cnt may be overwritten to inject faults.
   int cnt  = 0;
   bit hold = 0;

   task automatic compare_all();
      chk("locked",     32'(locked),     32'(m_lock));
      chk("err_pulse",  32'(err_pulse),  32'(m_err));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      chk("err_cnt",    32'(err_cnt),    32'(m_ecnt));
      chk("wrap_cnt",   32'(wrap_cnt),   32'(m_wcnt));
   endtask

   task automatic tick();
      q_in = WIDTH'(cnt);
      model_edge();
      @(posedge clk);
      #1;
      if (!hold) cnt = down ? (cnt + MAXV) % (MAXV + 1) : (cnt + 1) % (MAXV + 1);
      compare_all();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse();
      #2 n_rst = 1'b0;
      #1;
      chk("rst_locked",   32'(locked),     0);
      chk("rst_err",      32'(err_pulse),  0);
      chk("rst_wrap",     32'(wrap_pulse), 0);
      chk("rst_err_cnt",  32'(err_cnt),    0);
      chk("rst_wrap_cnt", 32'(wrap_cnt),   0);
      model_reset();
      #3 n_rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b1; en = 1'b0; clr = 1'b0; down = 1'b0; q_in = '0;
      model_reset();
      #2 n_rst = 1'b0;
      #2;
      chk("init_locked",   32'(locked),     0);
      chk("init_err",      32'(err_pulse),  0);
      chk("init_wrap",     32'(wrap_pulse), 0);
      chk("init_err_cnt",  32'(err_cnt),    0);
      chk("init_wrap_cnt", 32'(wrap_cnt),   0);
      @(posedge clk);
      #4 n_rst = 1'b1;

      // 1: count up from 0; lock after the fourth good compare.
      en = 1'b1; down = 1'b0; cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("t1_no_err", 32'(err_pulse), 0);
         if (i == 3) chk("t1_lock_early", 32'(locked), 0);
         if (i == 4) chk("t1_lock_rise", 32'(locked), 1);
      end

      // 2: reverse at 0; the 15->0 and 0->15 wraps land back to back.
      down = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) begin
            chk("t2_wrap_up",     32'(wrap_pulse), 1);
            chk("t2_wrap_cnt1",   32'(wrap_cnt),   1);
         end
         if (i == 1) begin
            chk("t2_wrap_down",   32'(wrap_pulse), 1);
            chk("t2_wrap_cnt2",   32'(wrap_cnt),   2);
         end
      end
      chk("t2_wrap_cnt", 32'(wrap_cnt), 2);
      chk("t2_err_cnt",  32'(err_cnt),  0);

      // 3: skip 5->7 while counting up.
      down = 1'b0;
      for (int k = 0; k < 20 && cnt != 5; k++) tick();
      tick();
      cnt = 7;
      tick();
      chk("t3_err",      32'(err_pulse), 1);
      chk("t3_err_cnt",  32'(err_cnt),   1);
      chk("t3_unlocked", 32'(locked),    0);
      tick();
      chk("t3_resync_ok", 32'(err_pulse), 0);
      tick(); tick();
      chk("t3_lock_early", 32'(locked), 0);
      tick();
      chk("t3_relock", 32'(locked), 1);

      // 4: stuck counter errors every edge; saturate, then clear alongside an error.
      hold = 1;
      for (int i = 0; i < 300; i++) tick();
      chk("t4_sat", 32'(err_cnt), 255);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t4_clr",      32'(err_cnt),   0);
      chk("t4_clr_err",  32'(err_pulse), 1);
      hold = 0;

      // 5: async reset mid-count; first edge after release is sync only.
      for (int i = 0; i < 5; i++) tick();
      reset_pulse();
      cnt = 12;
      tick();
      chk("t5_no_err",  32'(err_pulse), 0);
      chk("t5_err_cnt", 32'(err_cnt),   0);
      for (int i = 0; i < 3; i++) tick();

      // 6: disable for 3 cycles, re-enable with a jump 3 -> 9.
      for (int k = 0; k < 20 && cnt != 3; k++) tick();
      tick();
      en = 1'b0; hold = 1;
      for (int i = 0; i < 3; i++) tick();
      cnt = 9; hold = 0; en = 1'b1;
      tick();
      chk("t6_no_err", 32'(err_pulse), 0);
      chk("t6_locked0", 32'(locked), 0);
      tick(); tick(); tick();
      chk("t6_lock_early", 32'(locked), 0);
      tick();
      chk("t6_relock", 32'(locked), 1);

      // Random traffic: direction flips, glitches, freezes, clears, enable drops and resets.
      for (int i = 0; i < 600; i++) begin
         en   = ($urandom_range(0, 9) != 0);
         clr  = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 5) == 0) down = ~down;
         hold = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 11) == 0) cnt = int'($urandom_range(0, MAXV));
         tick();
         if ($urandom_range(0, 149) == 0) reset_pulse();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
